writeback_regfile: RTL and testbench

- Y86-64 pipeline write-back stage merged with the architectural register file.
- Holds the W pipeline register, latched from the memory stage, and commits valE/valM into 15 x 64-bit registers.
- Serves the decode stage: two combinational read ports (srcA/srcB), plus the W_* fields decode needs for forwarding.
- Produces the processor status, with a sticky halt.

---
 rtl/writeback_regfile.sv | 111 +++++++++++
 tb/tb_writeback_regfile.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, 15 x 64-bit architectural register file,
// two combinational decode read ports and a sticky processor status.
module writeback_regfile #(
    parameter logic [3:0]  RNONE = 4'hF,
    parameter int unsigned NREG  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        W_stall,
    input  logic        W_bubble,
    input  logic [3:0]  m_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    output logic [3:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic [3:0]  Stat,
    output logic        halted
);

    localparam logic [3:0] STAT_AOK  = 4'd1;
    localparam logic [3:0] ICODE_NOP = 4'd1;

    logic [63:0] regs_q [NREG];
    logic        halted_q;
    logic [3:0]  halt_stat_q;
    logic        write_en;

    // Only a healthy instruction commits; the faulting one is squashed here.
    assign write_en = (W_stat == STAT_AOK) && !halted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            W_stat  <= STAT_AOK;
            W_icode <= ICODE_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (halted_q) begin
            W_stat  <= W_stat;
        end else if (W_bubble) begin
            W_stat  <= STAT_AOK;
            W_icode <= ICODE_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (!W_stall) begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

    // Port M is tested first so it wins a shared destination (popq %rsp).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (W_dstM != RNONE && W_dstM == 4'(i)) begin
                    regs_q[i] <= W_valM;
                end else if (W_dstE != RNONE && W_dstE == 4'(i)) begin
                    regs_q[i] <= W_valE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q    <= 1'b0;
            halt_stat_q <= STAT_AOK;
        end else if (!halted_q && W_stat != STAT_AOK) begin
            halted_q    <= 1'b1;
            halt_stat_q <= W_stat;
        end
    end

    // No internal bypass: a same-cycle write is seen by decode through W forwarding.
    always_comb begin
        d_rvalA = '0;
        d_rvalB = '0;
        if (d_srcA != RNONE && 32'(d_srcA) < NREG) begin
            d_rvalA = regs_q[d_srcA];
        end
        if (d_srcB != RNONE && 32'(d_srcB) < NREG) begin
            d_rvalB = regs_q[d_srcB];
        end
    end

    assign Stat   = halted_q ? halt_stat_q : W_stat;
    assign halted = halted_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: commit latency, M-port priority, stall/bubble,
// sticky halt and asynchronous reset dropping a pending write.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        W_stall, W_bubble;
    logic [3:0]  m_stat, M_icode, M_dstE, M_dstM, d_srcA, d_srcB;
    logic [63:0] M_valE, m_valM;
    logic [63:0] d_rvalA, d_rvalB, W_valE, W_valM;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, Stat;
    logic        halted;

    int total = 0;
    int bad   = 0;

    writeback_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .W_stall  (W_stall),
        .W_bubble (W_bubble),
        .m_stat   (m_stat),
        .M_icode  (M_icode),
        .M_valE   (M_valE),
        .m_valM   (m_valM),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .d_rvalA  (d_rvalA),
        .d_rvalB  (d_rvalB),
        .W_stat   (W_stat),
        .W_icode  (W_icode),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .W_dstE   (W_dstE),
        .W_dstM   (W_dstM),
        .Stat     (Stat),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_m(input logic [3:0] stat, input logic [3:0] icode,
                          input logic [63:0] vale, input logic [63:0] valm,
                          input logic [3:0] dste, input logic [3:0] dstm);
        m_stat  = stat;
        M_icode = icode;
        M_valE  = vale;
        m_valM  = valm;
        M_dstE  = dste;
        M_dstM  = dstm;
    endtask

    task automatic load_nop();
        load_m(4'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        d_srcA   = 4'd0;
        d_srcB   = 4'd14;
        load_nop();
        tick();
        tick();
        rst = 1'b0;
        #2;

        check_val("rst_rvalA", d_rvalA, 64'd0);
        check_val("rst_rvalB", d_rvalB, 64'd0);
        check_val("rst_icode", W_icode, 4'd1);
        check_val("rst_stat", Stat, 4'd1);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_dstE", W_dstE, 4'hF);

        // Commit happens one edge after the instruction enters W.
        tick();
        load_m(4'd1, 4'd6, 64'h1234, 64'd0, 4'd3, 4'hF);
        d_srcA = 4'd3;
        tick();
        load_nop();
        check_val("w_dstE3", W_dstE, 4'd3);
        check_val("reg3_before", d_rvalA, 64'd0);
        tick();
        check_val("reg3_after", d_rvalA, 64'h1234);

        load_m(4'd1, 4'd11, 64'h100, 64'hABC, 4'd4, 4'd4);
        d_srcA = 4'd4;
        tick();
        load_nop();
        tick();
        check_val("reg4_mwins", d_rvalA, 64'hABC);

        load_m(4'd1, 4'd6, 64'd5, 64'd0, 4'd2, 4'hF);
        d_srcA = 4'd2;
        tick();
        load_nop();
        W_stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("stall_reg2", d_rvalA, 64'd5);
        check_val("stall_dstE", W_dstE, 4'd2);
        check_val("stall_valE", W_valE, 64'd5);
        W_bubble = 1'b1;
        tick();
        check_val("bubble_dstE", W_dstE, 4'hF);
        check_val("bubble_icode", W_icode, 4'd1);
        W_bubble = 1'b0;
        W_stall  = 1'b0;

        load_m(4'd2, 4'd0, 64'd7, 64'd0, 4'd1, 4'hF);
        d_srcA = 4'd1;
        d_srcB = 4'd5;
        tick();
        check_val("hlt_wstat", W_stat, 4'd2);
        check_val("hlt_stat_pre", Stat, 4'd2);
        check_val("hlt_halted_pre", halted, 1'b0);
        load_m(4'd1, 4'd6, 64'd99, 64'd0, 4'd5, 4'hF);
        tick();
        check_val("hlt_halted", halted, 1'b1);
        check_val("hlt_stat", Stat, 4'd2);
        check_val("hlt_reg1", d_rvalA, 64'd0);
        W_bubble = 1'b1;
        tick();
        tick();
        W_bubble = 1'b0;
        check_val("hlt_reg5", d_rvalB, 64'd0);
        check_val("hlt_stat_held", Stat, 4'd2);
        check_val("hlt_sticky", halted, 1'b1);

        // Clear halt, then fire reset mid-cycle while W holds a pending write.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check_val("rst2_halted", halted, 1'b0);
        load_m(4'd1, 4'd6, 64'hAA, 64'd0, 4'd6, 4'hF);
        d_srcA = 4'd6;
        d_srcB = 4'd3;
        tick();
        load_nop();
        check_val("pend_dstE", W_dstE, 4'd6);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_dstE", W_dstE, 4'hF);
        check_val("arst_stat", Stat, 4'd1);
        check_val("arst_reg3", d_rvalB, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_val("arst_reg6", d_rvalA, 64'd0);
        check_val("arst_halted", halted, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
